tl_ul_sram_responder: RTL
=========================

Name: tl_ul_sram_responder

Overview:
- TileLink-UL manager (responder) end of an A/D channel pair: accepts Get/PutFullData/PutPartialData on channel A and returns AccessAckData/AccessAck on channel D.
- Backed by an internal word-addressed register-array RAM.
- Sits downstream of a TL repeater/monitor pair, as the leaf target for small scratchpad and test-memory windows.
- Single-beat only (size <= 3, 64-bit data bus), one outstanding response buffered.

Parameters:
ADDR_W, 25, A-channel address width
SRC_W, 3, source ID width
DEPTH, 256, number of 64-bit words (power of 2, >= 2)
BASE_ADDR, 0, byte base address of the window (DEPTH*8 aligned)

Ports:
clock  in  1  sole clock, all state on rising edge
reset  in  1  synchronous, active-high
a_valid  in  1  A request valid
a_ready  out  1  A request accept
a_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get
a_param  in  3  must be 0
a_size  in  3  log2 bytes
a_source  in  SRC_W  requester ID
a_address  in  ADDR_W  byte address
a_mask  in  8  byte lanes
a_data  in  64  write data
a_corrupt  in  1  write data poisoned
d_valid  out  1  D response valid
d_ready  in  1  D response accept
d_opcode  out  3  0=AccessAck, 1=AccessAckData
d_param  out  2  always 0
d_size  out  3  echo of a_size
d_source  out  SRC_W  echo of a_source
d_denied  out  1  request rejected
d_data  out  64  read data (0 when not AccessAckData or denied)
d_corrupt  out  1  read data poisoned

Behaviour:
- Reset: d_valid=0; d_opcode/d_param/d_size/d_source/d_denied/d_data/d_corrupt=0. Pending response discarded. RAM contents are not reset.
- State: EMPTY (no response held) / FULL (response held in D register).
- a_ready = (state==EMPTY) | d_ready.
  - Combinational d_ready->a_ready path is permitted.
  - a_ready is never dependent on a_valid.
- A fire (a_valid&a_ready) in cycle N: response registered, d_valid=1 in cycle N+1. With d_ready held high, throughput is 1 request/cycle.
- Transitions:
  - EMPTY + A fire -> FULL.
  - FULL + D fire with no A fire -> EMPTY.
  - FULL + D fire + A fire same cycle -> stays FULL with the new response.
  - FULL + !d_ready -> hold all D outputs stable.
- Denial rules, checked in this priority order (any hit: no RAM write, d_denied=1, d_data=0, d_corrupt=0, d_opcode still 1 for Get and 0 for Put):
  - opcode not in {0,1,4}
  - a_param!=0
  - a_size>3
  - address not aligned to 2^size
  - address outside [BASE_ADDR, BASE_ADDR+DEPTH*8)
  - PutFull whose mask != the exact lane set implied by size/address[2:0]
- Word index = (a_address-BASE_ADDR)[log2(DEPTH)+2:3]. Lanes (size<3) = 2^size bytes starting at address[2:0].
- PutPartial: writes only lanes with a_mask=1. Mask bits outside the size lanes are ignored. A zero mask is legal (ack, no write).
- Get: d_data = full 64-bit word read at A fire. Mask is ignored.
- Ordering: a write accepted in cycle N is visible to a Get accepted in cycle N+1 (no stale read).

Optional Feature:
- Macro: TL_UL_SRAM_RESPONDER_POISON_EN.
- Defined:
  - Adds a per-word poison bit, reset to 0 (only state reset besides D).
  - A non-denied Put with a_corrupt=1 sets the poison bit of the addressed word; one with a_corrupt=0 clears it.
  - A non-denied Get returns d_corrupt = that word's poison bit.
- Undefined:
  - No poison storage; a_corrupt is ignored (the write is still performed).
  - d_corrupt is tied to 0.

Test Plan:
- Reset asserted mid-response (d_valid=1, d_ready=0) -> next cycle d_valid=0 and a_ready=1; no stale response reappears.
- PutFull size=3 addr=BASE+0x10 data=0x1122334455667788 mask=0xFF, then Get same addr back-to-back, d_ready=1 -> d: AccessAck then cycle after AccessAckData data=0x1122334455667788, d_denied=0, sources echoed.
- PutPartial size=3 addr=BASE+0x10 mask=0x0F data=0xAAAAAAAA_BBBBBBBB, then Get -> 0x11223344_BBBBBBBB.
- Denials:
  - Get addr=BASE+DEPTH*8 -> d_denied=1, d_data=0.
  - Get size=2 addr=BASE+0x2 -> d_denied=1.
  - opcode=2 -> d_opcode=0, d_denied=1.
  - RAM unchanged in all three cases.
- Backpressure: d_ready=0 for 5 cycles with a_valid=1 -> a_ready=0 and D outputs stable. Raise d_ready -> D fire and next A fire occur in the same cycle.
- Poison (macro defined only): PutFull a_corrupt=1, then Get -> d_corrupt=1. Repeat without the macro -> d_corrupt=0, data is the written value.

Source files
------------

// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL single-beat responder backed by a word-addressed register-array RAM.
// Optional macro TL_UL_SRAM_RESPONDER_POISON_EN adds per-word poison tracking on d_corrupt.
module tl_ul_sram_responder #(
   parameter int ADDR_W    = 25,
   parameter int SRC_W     = 3,
   parameter int DEPTH     = 256,
   parameter int BASE_ADDR = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [2:0]        a_opcode,
   input  logic [2:0]        a_param,
   input  logic [2:0]        a_size,
   input  logic [SRC_W-1:0]  a_source,
   input  logic [ADDR_W-1:0] a_address,
   input  logic [7:0]        a_mask,
   input  logic [63:0]       a_data,
   input  logic              a_corrupt,
   output logic              d_valid,
   input  logic              d_ready,
   output logic [2:0]        d_opcode,
   output logic [1:0]        d_param,
   output logic [2:0]        d_size,
   output logic [SRC_W-1:0]  d_source,
   output logic              d_denied,
   output logic [63:0]       d_data,
   output logic              d_corrupt,
   output logic              o_dbg_state
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] LP_BASE = (ADDR_W+1)'(BASE_ADDR);
   localparam logic [ADDR_W:0] LP_SPAN = (ADDR_W+1)'(DEPTH * 8);

   localparam logic [2:0] OP_PUT_FULL = 3'd0;
   localparam logic [2:0] OP_PUT_PART = 3'd1;
   localparam logic [2:0] OP_GET      = 3'd4;

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]       r_state;
   logic [2:0]       r_d_opcode;
   logic [2:0]       r_d_size;
   logic [SRC_W-1:0] r_d_source;
   logic             r_d_denied;
   logic [63:0]      r_d_data;
   logic             r_d_corrupt;
   logic [63:0]      r_mem [DEPTH];

   logic [ADDR_W:0]  w_off_ext;
   logic [IDX_W-1:0] w_idx;
   logic [7:0]       w_lanes;
   logic             w_aligned;
   logic             w_in_range;
   logic             w_denied;
   logic             w_is_get;
   logic             w_is_put;
   logic             w_a_fire;
   logic             w_wr_en;
   logic [7:0]       w_be;
   logic [63:0]      w_rd_data;
   logic             w_rd_poison;
   logic             w_unused;

   // Handshake: a beat moves when valid & ready are both high at a rising edge;
   // the D register is a one-entry buffer, so A may enter whenever D is empty or draining.
   assign d_valid     = (r_state == ST_FULL);
   assign a_ready     = (r_state == ST_EMPTY) | d_ready;
   assign o_dbg_state = r_state;

   assign d_opcode  = r_d_opcode;
   assign d_param   = 2'b00;
   assign d_size    = r_d_size;
   assign d_source  = r_d_source;
   assign d_denied  = r_d_denied;
   assign d_data    = r_d_data;
   assign d_corrupt = r_d_corrupt;

   // Addresses below the base wrap to a huge offset, so one compare covers both bounds.
   assign w_off_ext  = {1'b0, a_address} - LP_BASE;
   assign w_in_range = (w_off_ext < LP_SPAN);
   assign w_idx      = w_off_ext[IDX_W+2:3];

   assign w_is_get = (a_opcode == OP_GET);
   assign w_is_put = (a_opcode == OP_PUT_FULL) | (a_opcode == OP_PUT_PART);

   always_comb begin
      w_lanes   = 8'hFF;
      w_aligned = 1'b1;
      case (a_size)
         3'd0: begin
            w_lanes   = 8'h01 << a_address[2:0];
            w_aligned = 1'b1;
         end
         3'd1: begin
            w_lanes   = 8'h03 << a_address[2:0];
            w_aligned = ~a_address[0];
         end
         3'd2: begin
            w_lanes   = 8'h0F << a_address[2:0];
            w_aligned = (a_address[1:0] == 2'b00);
         end
         default: begin
            w_lanes   = 8'hFF;
            w_aligned = (a_address[2:0] == 3'b000);
         end
      endcase
   end

   always_comb begin
      w_denied = 1'b0;
      if (!(w_is_put || w_is_get)) begin
         w_denied = 1'b1;
      end else if (a_param != 3'd0) begin
         w_denied = 1'b1;
      end else if (a_size > 3'd3) begin
         w_denied = 1'b1;
      end else if (!w_aligned) begin
         w_denied = 1'b1;
      end else if (!w_in_range) begin
         w_denied = 1'b1;
      end else if ((a_opcode == OP_PUT_FULL) && (a_mask != w_lanes)) begin
         w_denied = 1'b1;
      end
   end

   assign w_a_fire  = a_valid & a_ready;
   assign w_wr_en   = w_a_fire & ~w_denied & w_is_put;
   assign w_be      = w_lanes & a_mask;
   assign w_rd_data = r_mem[w_idx];

   always_ff @(posedge clock) begin
      if (w_wr_en) begin
         for (int b = 0; b < 8; b++) begin
            if (w_be[b]) begin
               r_mem[w_idx][8*b +: 8] <= a_data[8*b +: 8];
            end
         end
      end
   end

`ifdef TL_UL_SRAM_RESPONDER_POISON_EN
   logic [DEPTH-1:0] r_poison;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_poison <= '0;
      end else if (w_wr_en) begin
         r_poison[w_idx] <= a_corrupt;
      end
   end

   assign w_rd_poison = r_poison[w_idx];
   assign w_unused    = ^{w_off_ext[ADDR_W:IDX_W+3], w_off_ext[2:0]};
`else
   assign w_rd_poison = 1'b0;
   assign w_unused    = ^{w_off_ext[ADDR_W:IDX_W+3], w_off_ext[2:0], a_corrupt};
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_EMPTY;
         r_d_opcode  <= 3'd0;
         r_d_size    <= 3'd0;
         r_d_source  <= '0;
         r_d_denied  <= 1'b0;
         r_d_data    <= 64'd0;
         r_d_corrupt <= 1'b0;
      end else if (w_a_fire) begin
         r_state     <= ST_FULL;
         r_d_opcode  <= w_is_get ? 3'd1 : 3'd0;
         r_d_size    <= a_size;
         r_d_source  <= a_source;
         r_d_denied  <= w_denied;
         r_d_data    <= (w_is_get && !w_denied) ? w_rd_data : 64'd0;
         r_d_corrupt <= w_is_get & ~w_denied & w_rd_poison;
      end else if ((r_state == ST_FULL) && d_ready) begin
         r_state <= ST_EMPTY;
      end
   end

endmodule
